// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the PC fetch unit: word width, reset PC,
// expected PC increment and the fetch FSM encoding.
package pc_fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int    PC_INCR_DEFAULT  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // PC_INCR is assumed to be a power of two; any low bit inside it is illegal.
  function automatic logic is_misaligned(input word_t addr, input int incr);
    word_t mask;
    mask = word_t'(incr - 1);
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-unit buses: instruction memory request/response and the decode handshake.
// imem: imem_req/imem_addr held until imem_rdy; decode: instr held while
// instr_valid is high, transfer happens in a cycle where instr_valid && instr_ready.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_rdy;
  word_t imem_data;
  word_t instr;
  logic  instr_valid;
  logic  instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_rdy, imem_data, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_rdy, imem_data, instr_ready
  );

endinterface

// File: rtl/pc_fetch_npc_sel.sv
// Next-PC select (jump > branch > sequential) and misalignment check of the
// selected target; purely combinational, only meaningful in the accept cycle.
module pc_fetch_npc_sel
  import pc_fetch_pkg::*;
#(
  parameter int PC_INCR = PC_INCR_DEFAULT
) (
  input  logic  jump,
  input  word_t jump_target,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  word_t pc_plus4,
  output word_t npc,
  output logic  misaligned
);

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = jump_target;
    end else if (branch_taken) begin
      npc = branch_target;
    end
  end

  assign misaligned = is_misaligned(npc, PC_INCR);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch sequencer: requests the word at pc, hands it to decode,
// and on acceptance advances pc from an external adder or a redirect target.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    PC_INCR  = PC_INCR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output word_t      pc,
  input  word_t      pc_plus4,
  input  logic       jump,
  input  word_t      jump_target,
  input  logic       branch_taken,
  input  word_t      branch_target,
  input  logic       halt,
  output logic       err,
  output logic [1:0] state_dbg,
  pc_fetch_if.master bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  word_t      instr_q;
  word_t      npc;
  logic       misaligned;
  logic       accept;

  pc_fetch_npc_sel #(
    .PC_INCR(PC_INCR)
  ) npc_sel (
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_plus4     (pc_plus4),
    .npc          (npc),
    .misaligned   (misaligned)
  );

  assign accept = (state == ST_VALID) && bus.instr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_rdy) state_nxt = ST_VALID;
      end
      ST_VALID: begin
        if (bus.instr_ready) begin
          if (misaligned || halt) begin
            state_nxt = ST_HALT;
          end else if (!en) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_FETCH) && bus.imem_rdy) begin
        instr_q <= bus.imem_data;
      end
      // A misaligned target leaves pc pointing at the offending instruction.
      if (accept) begin
        if (misaligned) begin
          err <= 1'b1;
        end else begin
          pc <= npc;
        end
      end
    end
  end

  // Request and valid are decoded from state, so reset drops them at once
  // and they can never be high together.
  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == ST_VALID);
  assign state_dbg       = state;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: external PC adder, memory/decode driver
// tasks, instruction scoreboard, a redirect vector table and corner sequences.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  word_t      pc;
  word_t      pc_plus4;
  logic       jump;
  word_t      jump_target;
  logic       branch_taken;
  word_t      branch_target;
  logic       halt;
  logic       err;
  logic [1:0] state_dbg;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .err          (err),
    .state_dbg    (state_dbg),
    .bus          (bus)
  );

  // External PC adder: a = pc, b = 4.
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request and valid must never overlap.
  always @(negedge clk) begin
    if (!rst) check("req_valid_excl", {31'd0, bus.imem_req & bus.instr_valid}, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for the request, check its address (held for 'delay' cycles),
  // answer it and check the registered instruction a cycle later.
  // Redirect inputs carry noise here; they must only matter on accept.
  task automatic do_fetch(input logic [31:0] exp_addr, input int delay);
    int          n;
    logic [31:0] d;
    n             = 0;
    en            = 1'b1;
    jump          = 1'b1;
    jump_target   = 32'h0000_0055;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0777;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, bus.imem_req}, 32'd1);
    check("fetch_addr", bus.imem_addr, exp_addr);
    for (int k = 0; k < delay; k++) begin
      check("req_held", {31'd0, bus.imem_req}, 32'd1);
      check("addr_held", bus.imem_addr, exp_addr);
      @(negedge clk);
    end
    d = $urandom;
    bus.imem_rdy  = 1'b1;
    bus.imem_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    bus.imem_rdy  = 1'b0;
    bus.imem_data = $urandom;
    check("valid_up", {31'd0, bus.instr_valid}, 32'd1);
    check("req_down", {31'd0, bus.imem_req}, 32'd0);
    last_instr = exp_q.pop_front();
    check("instr_data", bus.instr, last_instr);
  endtask

  task automatic do_accept(input logic j, input logic [31:0] jt, input logic b,
                           input logic [31:0] bt, input logic h, input logic e);
    jump            = j;
    jump_target     = jt;
    branch_taken    = b;
    branch_target   = bt;
    halt            = h;
    en              = e;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    jump            = 1'b0;
    branch_taken    = 1'b0;
    halt            = 1'b0;
  endtask

  typedef struct {
    logic        j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic        h;
    logic        e;
    logic [31:0] exp_pc;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] cur_pc;
  int          delays[4];

  initial begin
    vecs[0] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0014, ST_FETCH};
    vecs[1] = '{1'b1, 32'h100,       1'b1, 32'h200,   1'b0, 1'b1, 32'h0000_0100, ST_FETCH};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h200,   1'b0, 1'b1, 32'h0000_0200, ST_FETCH};
    vecs[3] = '{1'b1, 32'h300,       1'b0, 32'h9999,  1'b0, 1'b1, 32'h0000_0300, ST_FETCH};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b0, 32'h0000_0304, ST_IDLE};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFFF_FFFC, ST_FETCH};
    vecs[6] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0000, ST_FETCH};
    delays  = '{0, 0, 3, 0};

    rst             = 1'b1;
    en              = 1'b0;
    jump            = 1'b0;
    jump_target     = '0;
    branch_taken    = 1'b0;
    branch_target   = '0;
    halt            = 1'b0;
    bus.imem_rdy    = 1'b0;
    bus.imem_data   = '0;
    bus.instr_ready = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst = 1'b0;

    // Sequential stream 0,4,8,C; word at 0x8 waits 3 cycles for imem_rdy
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'(i * 4), delays[i]);
      do_accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("seq_pc", pc, 32'((i + 1) * 4));
      check("seq_valid_pulse", {31'd0, bus.instr_valid}, 32'd0);
      check("seq_state", {30'd0, state_dbg}, {30'd0, ST_FETCH});
    end

    // Redirect vector table
    cur_pc = 32'h10;
    for (int v = 0; v < 7; v++) begin
      do_fetch(cur_pc, 0);
      do_accept(vecs[v].j, vecs[v].jt, vecs[v].b, vecs[v].bt, vecs[v].h, vecs[v].e);
      check("vec_pc", pc, vecs[v].exp_pc);
      check("vec_state", {30'd0, state_dbg}, {30'd0, vecs[v].exp_st});
      check("vec_err", {31'd0, err}, 32'd0);
      cur_pc = vecs[v].exp_pc;
    end

    // Decode stalls 5 cycles, then accepts with halt
    do_fetch(32'h0, 0);
    for (int k = 0; k < 5; k++) begin
      check("stall_instr", bus.instr, last_instr);
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      @(negedge clk);
    end
    do_accept(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("halt_pc", pc, 32'h4);
    check("halt_state", {30'd0, state_dbg}, {30'd0, ST_HALT});
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halt_req", {31'd0, bus.imem_req}, 32'd0);
      check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("halt_frozen", pc, 32'h4);
    end

    // Reset leaves HALT; fetch restarts at RESET_PC, then jump to 0x40
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_fetch(32'h0, 0);
    do_accept(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
    check("pre_rst_addr", bus.imem_addr, 32'h40);

    // Asynchronous reset in the middle of a FETCH cycle
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, bus.imem_req}, 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_addr", bus.imem_addr, 32'h0);
    check("arst_instr", bus.instr, 32'h0);
    en            = 1'b0;
    bus.imem_rdy  = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.imem_rdy = 1'b0;
    check("late_rdy_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check("late_rdy_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("late_rdy_instr", bus.instr, 32'h0);

    // Misaligned branch target on accept
    do_fetch(32'h0, 0);
    do_accept(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1);
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_state", {30'd0, state_dbg}, {30'd0, ST_HALT});
    check("mis_pc", pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mis_no_req", {31'd0, bus.imem_req}, 32'd0);
      check("mis_err_sticky", {31'd0, err}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
